// File: rtl/ccip_if_pkg.sv
// CCI-P request header types shared by the AFU-facing read path.
// t_ccip_ReqMemHdr is the TX0/TX1 memory request header as the AFU drives it.
package ccip_if_pkg;

   typedef struct packed {
      logic [1:0]  vc_sel;
      logic [1:0]  rsvd1;
      logic [1:0]  cl_len;
      logic [3:0]  req_type;
      logic [5:0]  rsvd0;
      logic [41:0] address;
      logic [15:0] mdata;
   } t_ccip_ReqMemHdr;

endpackage

// File: rtl/ccip_rdreq_credit_gate_pkg.sv
// Shared definitions for the TX0 read-request credit gate.
// Holds the gate state encoding and the credit-limit helper derived from the
// reorder-buffer radix.
package ccip_rdgate_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      ISSUE        = 2'd1,
      NOCREDIT     = 2'd2,
      BACKPRESSURE = 2'd3
   } t_gate_state;

   localparam int CCIP_ROB_RADIX_DEFAULT = 8;

   // One credit per reorder-buffer slot.
   function automatic int credit_limit(input int rob_radix);
      return 1 << rob_radix;
   endfunction

   localparam int CREDIT_LIMIT_DEFAULT = credit_limit(CCIP_ROB_RADIX_DEFAULT);

endpackage

// File: rtl/ccip_rdreq_credit_gate_if.sv
// Bundle of the AFU-side and ROB-side signals of the read-request gate.
//   master : environment view (AFU + reorder buffer drive requests/responses)
//   slave  : gate view (ccip_rdreq_credit_gate)
// Signals: afu_c0_hdr/afu_c0_rdvalid/afu_c0_almfull (AFU request channel),
// rob_c0_hdr/rob_c0_rdvalid/rob_c0_almfull (forwarded channel),
// rob_rx_rdvalid (credit return), outstanding, gate_state, sticky errors.
interface ccip_rdreq_credit_gate_if
   import ccip_if_pkg::*;
#(
   parameter int CCIP_ROB_RADIX = 8
);
   t_ccip_ReqMemHdr         afu_c0_hdr;
   logic                    afu_c0_rdvalid;
   logic                    afu_c0_almfull;
   t_ccip_ReqMemHdr         rob_c0_hdr;
   logic                    rob_c0_rdvalid;
   logic                    rob_c0_almfull;
   logic                    rob_rx_rdvalid;
   logic [CCIP_ROB_RADIX:0] outstanding;
   logic [1:0]              gate_state;
   logic                    overflow_err;
   logic                    underflow_err;

   modport master (
      output afu_c0_hdr, afu_c0_rdvalid, rob_c0_almfull, rob_rx_rdvalid,
      input  afu_c0_almfull, rob_c0_hdr, rob_c0_rdvalid, outstanding,
             gate_state, overflow_err, underflow_err
   );

   modport slave (
      input  afu_c0_hdr, afu_c0_rdvalid, rob_c0_almfull, rob_rx_rdvalid,
      output afu_c0_almfull, rob_c0_hdr, rob_c0_rdvalid, outstanding,
             gate_state, overflow_err, underflow_err
   );
endinterface

// File: rtl/ccip_rdreq_credit_gate_fifo.sv
// rdgate_fifo: small show-ahead FIFO holding pending read-request headers.
// Ports: clk, rst (async, active high), push/d, pop, q (head, valid when
// !empty), count (0..2**RADIX), empty, full. A push while full is ignored;
// a pop while empty is ignored.
module rdgate_fifo #(
   parameter int WIDTH = 8,
   parameter int RADIX = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] d,
   input  logic             pop,
   output logic [WIDTH-1:0] q,
   output logic [RADIX:0]   count,
   output logic             empty,
   output logic             full
);
   localparam int DEPTH = 1 << RADIX;
   localparam int CW    = RADIX + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [RADIX-1:0] wr_ptr;
   logic [RADIX-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign q       = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + RADIX'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + RADIX'(1);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // Storage needs no reset: entries are only observed once count covers them.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= d;
   end
endmodule

// File: rtl/ccip_rdreq_credit_gate.sv
// ccip_rdreq_credit_gate: buffers AFU TX0 read requests and forwards them to
// the reorder buffer only while read credits (one per ROB slot) remain.
// Ports: clk, softreset (async, active high), gate (slave modport carrying
// the AFU request channel, the forwarded ROB channel, the credit-return
// pulse rob_rx_rdvalid, outstanding count, gate_state and sticky errors).
//
//   state        | meaning
//   -------------+--------------------------------------------------
//   IDLE         | request FIFO empty
//   ISSUE        | requests pending, credit available, no backpressure
//   NOCREDIT     | requests pending, all credits in flight
//   BACKPRESSURE | requests pending, credit available, ROB almost full
module ccip_rdreq_credit_gate
   import ccip_if_pkg::*;
   import ccip_rdgate_pkg::*;
#(
   parameter int CCIP_ROB_RADIX = 8,
   parameter int REQ_FIFO_RADIX = 3,
   parameter int ALMFULL_GUARD  = 4
) (
   input logic                     clk,
   input logic                     softreset,
   ccip_rdreq_credit_gate_if.slave gate
);
   localparam int DEPTH = 1 << REQ_FIFO_RADIX;
   localparam int OW    = CCIP_ROB_RADIX + 1;
   localparam int CW    = REQ_FIFO_RADIX + 1;

   localparam logic [OW-1:0] LIMIT_V    = OW'(credit_limit(CCIP_ROB_RADIX));
   localparam logic [CW-1:0] ALM_THRESH = CW'(DEPTH - ALMFULL_GUARD);

   localparam logic [1:0] ST_IDLE         = 2'(IDLE);
   localparam logic [1:0] ST_ISSUE        = 2'(ISSUE);
   localparam logic [1:0] ST_NOCREDIT     = 2'(NOCREDIT);
   localparam logic [1:0] ST_BACKPRESSURE = 2'(BACKPRESSURE);

   t_ccip_ReqMemHdr fifo_q;
   logic [CW-1:0]   fifo_count;
   logic [CW-1:0]   count_next;
   logic            fifo_empty;
   logic            fifo_full;
   logic            push_ok;
   logic            issue;

   logic [OW-1:0]   outstanding_q;
   logic [OW-1:0]   outstanding_next;
   logic [1:0]      state_q;
   logic [1:0]      state_next;
   logic            almfull_q;
   logic            rdvalid_q;
   t_ccip_ReqMemHdr hdr_q;
   logic            overflow_q;
   logic            underflow_q;

   rdgate_fifo #(
      .WIDTH ($bits(t_ccip_ReqMemHdr)),
      .RADIX (REQ_FIFO_RADIX)
   ) u_fifo (
      .clk   (clk),
      .rst   (softreset),
      .push  (gate.afu_c0_rdvalid),
      .d     (gate.afu_c0_hdr),
      .pop   (issue),
      .q     (fifo_q),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // ROB almost-full is used combinationally so it blocks the issue on the
   // same edge it is sampled.
   assign issue      = !fifo_empty && (outstanding_q < LIMIT_V) && !gate.rob_c0_almfull;
   assign push_ok    = gate.afu_c0_rdvalid && !fifo_full;
   assign count_next = fifo_count + CW'(push_ok) - CW'(issue);

   // A response at zero outstanding is spurious: the counter holds and the
   // error flag records it.
   always_comb begin
      outstanding_next = outstanding_q;
      if (issue && !gate.rob_rx_rdvalid) begin
         outstanding_next = outstanding_q + OW'(1);
      end else if (!issue && gate.rob_rx_rdvalid && (outstanding_q != '0)) begin
         outstanding_next = outstanding_q - OW'(1);
      end
   end

   // State reflects the situation after this cycle's push/pop; a credit
   // stall outranks ROB backpressure.
   always_comb begin
      state_next = ST_ISSUE;
      if (count_next == '0) begin
         state_next = ST_IDLE;
      end else if (outstanding_next == LIMIT_V) begin
         state_next = ST_NOCREDIT;
      end else if (gate.rob_c0_almfull) begin
         state_next = ST_BACKPRESSURE;
      end
   end

   always_ff @(posedge clk or posedge softreset) begin
      if (softreset) begin
         rdvalid_q     <= 1'b0;
         hdr_q         <= '0;
         almfull_q     <= 1'b1;
         outstanding_q <= '0;
         state_q       <= ST_IDLE;
         overflow_q    <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         rdvalid_q     <= issue;
         if (issue) hdr_q <= fifo_q;
         almfull_q     <= (count_next >= ALM_THRESH);
         outstanding_q <= outstanding_next;
         state_q       <= state_next;
         if (gate.afu_c0_rdvalid && fifo_full) overflow_q <= 1'b1;
         if (gate.rob_rx_rdvalid && (outstanding_q == '0)) underflow_q <= 1'b1;
      end
   end

   assign gate.rob_c0_rdvalid = rdvalid_q;
   assign gate.rob_c0_hdr     = hdr_q;
   assign gate.afu_c0_almfull = almfull_q;
   assign gate.outstanding    = outstanding_q;
   assign gate.gate_state     = state_q;
   assign gate.overflow_err   = overflow_q;
   assign gate.underflow_err  = underflow_q;
endmodule

// File: tb/tb_ccip_rdreq_credit_gate.sv
// Bench for ccip_rdreq_credit_gate: two instances (4 and 8 credits) share one
// stimulus stream; a queue-level reference model predicts every output.
module tb_ccip_rdreq_credit_gate;
   import ccip_if_pkg::*;

   localparam int DEPTH = 8;
   localparam int GUARD = 4;

   logic clk = 1'b0;
   logic softreset = 1'b1;
   always #5 clk = ~clk;

   logic            drv_vld  = 1'b0;
   t_ccip_ReqMemHdr drv_hdr  = '0;
   logic            drv_ralm = 1'b0;
   logic            drv_rx   = 1'b0;

   ccip_rdreq_credit_gate_if #(.CCIP_ROB_RADIX(2)) ifa ();
   ccip_rdreq_credit_gate_if #(.CCIP_ROB_RADIX(3)) ifb ();

   assign ifa.afu_c0_hdr     = drv_hdr;
   assign ifa.afu_c0_rdvalid = drv_vld;
   assign ifa.rob_c0_almfull = drv_ralm;
   assign ifa.rob_rx_rdvalid = drv_rx;
   assign ifb.afu_c0_hdr     = drv_hdr;
   assign ifb.afu_c0_rdvalid = drv_vld;
   assign ifb.rob_c0_almfull = drv_ralm;
   assign ifb.rob_rx_rdvalid = drv_rx;

   ccip_rdreq_credit_gate #(.CCIP_ROB_RADIX(2), .REQ_FIFO_RADIX(3), .ALMFULL_GUARD(GUARD)) dut_a (
      .clk(clk), .softreset(softreset), .gate(ifa));
   ccip_rdreq_credit_gate #(.CCIP_ROB_RADIX(3), .REQ_FIFO_RADIX(3), .ALMFULL_GUARD(GUARD)) dut_b (
      .clk(clk), .softreset(softreset), .gate(ifb));

   // reference model: per instance a list of pending headers plus counters
   t_ccip_ReqMemHdr mq [2][DEPTH];
   int              m_cnt [2];
   int              m_out [2];
   int              m_lim [2] = '{4, 8};
   bit              m_vld [2];
   bit              m_alm [2];
   bit              m_ovf [2];
   bit              m_unf [2];
   int              m_st  [2];
   t_ccip_ReqMemHdr m_hdr [2];

   int n_tests = 0;
   int n_fail  = 0;
   int issued;
   int issued_b;

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_out[i] = 0; m_vld[i] = 0; m_alm[i] = 1;
         m_ovf[i] = 0; m_unf[i] = 0; m_st[i] = 0; m_hdr[i] = '0;
      end
   endfunction

   function automatic void model_edge();
      bit full;
      bit iss;
      for (int i = 0; i < 2; i++) begin
         full = (m_cnt[i] == DEPTH);
         iss  = (m_cnt[i] > 0) && (m_out[i] < m_lim[i]) && !drv_ralm;
         m_vld[i] = iss;
         if (iss) begin
            m_hdr[i] = mq[i][0];
            for (int k = 0; k < DEPTH - 1; k++) mq[i][k] = mq[i][k+1];
            m_cnt[i]--;
         end
         if (drv_vld) begin
            if (full) m_ovf[i] = 1;
            else begin
               mq[i][m_cnt[i]] = drv_hdr;
               m_cnt[i]++;
            end
         end
         if (drv_rx && m_out[i] == 0) m_unf[i] = 1;
         if (iss && !drv_rx) m_out[i]++;
         else if (drv_rx && !iss && m_out[i] > 0) m_out[i]--;
         m_alm[i] = (m_cnt[i] >= DEPTH - GUARD);
         if (m_cnt[i] == 0) m_st[i] = 0;
         else if (m_out[i] == m_lim[i]) m_st[i] = 2;
         else if (drv_ralm) m_st[i] = 3;
         else m_st[i] = 1;
      end
   endfunction

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_inst(input int i, input logic vld, input t_ccip_ReqMemHdr hdr,
                             input logic alm, input int out, input logic [1:0] st,
                             input logic ovf, input logic unf);
      string p;
      p = (i == 0) ? "a" : "b";
      chk({p, ".rdvalid"},   80'(vld), 80'(m_vld[i]));
      chk({p, ".hdr"},       80'(hdr), 80'(m_hdr[i]));
      chk({p, ".almfull"},   80'(alm), 80'(m_alm[i]));
      chk({p, ".outstand"},  80'(out), 80'(m_out[i]));
      chk({p, ".state"},     80'(st),  80'(m_st[i]));
      chk({p, ".overflow"},  80'(ovf), 80'(m_ovf[i]));
      chk({p, ".underflow"}, 80'(unf), 80'(m_unf[i]));
   endtask

   task automatic check_all();
      check_inst(0, ifa.rob_c0_rdvalid, ifa.rob_c0_hdr, ifa.afu_c0_almfull, int'(ifa.outstanding),
                 ifa.gate_state, ifa.overflow_err, ifa.underflow_err);
      check_inst(1, ifb.rob_c0_rdvalid, ifb.rob_c0_hdr, ifb.afu_c0_almfull, int'(ifb.outstanding),
                 ifb.gate_state, ifb.overflow_err, ifb.underflow_err);
   endtask

   function automatic t_ccip_ReqMemHdr mk(input logic [15:0] md);
      t_ccip_ReqMemHdr h;
      h         = '0;
      h.mdata   = md;
      h.address = 42'($urandom);
      h.cl_len  = 2'($urandom_range(0, 3));
      return h;
   endfunction

   // drive at posedge+1, model and check at the following posedge+1
   task automatic step(input bit v, input logic [15:0] md, input bit ralm, input bit rx);
      drv_vld  = v;
      drv_hdr  = v ? mk(md) : '0;
      drv_ralm = ralm;
      drv_rx   = rx;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic assert_reset();
      drv_vld = 0; drv_ralm = 0; drv_rx = 0; drv_hdr = '0;
      #3;
      softreset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic release_reset();
      #3;
      softreset = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("rst.almfull", 80'(ifa.afu_c0_almfull), 80'(1));
      release_reset();

      // single read
      step(1, 16'h1234, 0, 0);
      chk("rel.almfull_low", 80'(ifa.afu_c0_almfull), 80'(0));
      chk("single.lat1", 80'(ifa.rob_c0_rdvalid), 80'(0));
      step(0, 16'h0, 0, 0);
      chk("single.vld", 80'(ifa.rob_c0_rdvalid), 80'(1));
      chk("single.mdata", 80'(ifa.rob_c0_hdr.mdata), 80'(16'h1234));
      chk("single.out", 80'(ifa.outstanding), 80'(1));
      step(0, 16'h0, 0, 0);
      chk("single.pulse", 80'(ifa.rob_c0_rdvalid), 80'(0));
      step(0, 16'h0, 0, 1);
      chk("single.ret", 80'(ifa.outstanding), 80'(0));

      // credit exhaustion on the 4-credit instance
      assert_reset();
      release_reset();
      issued = 0;
      for (int k = 0; k < 6; k++) begin
         step(1, 16'h0100 + 16'(k), 0, 0);
         issued += int'(ifa.rob_c0_rdvalid);
      end
      repeat (4) begin
         step(0, 16'h0, 0, 0);
         issued += int'(ifa.rob_c0_rdvalid);
      end
      chk("credit.issued", 80'(issued), 80'(4));
      chk("credit.state", 80'(ifa.gate_state), 80'(2));
      step(0, 16'h0, 0, 1);
      chk("credit.ret_no_issue", 80'(ifa.rob_c0_rdvalid), 80'(0));
      step(0, 16'h0, 0, 0);
      chk("credit.fifth", 80'(ifa.rob_c0_rdvalid), 80'(1));
      chk("credit.fifth_md", 80'(ifa.rob_c0_hdr.mdata), 80'(16'h0104));
      chk("credit.out", 80'(ifa.outstanding), 80'(4));

      // ROB backpressure
      assert_reset();
      release_reset();
      issued = 0;
      for (int k = 0; k < 3; k++) begin
         step(1, 16'h0200 + 16'(k), 1, 0);
         issued += int'(ifa.rob_c0_rdvalid);
      end
      chk("bp.no_issue", 80'(issued), 80'(0));
      chk("bp.state", 80'(ifa.gate_state), 80'(3));
      for (int k = 0; k < 3; k++) begin
         step(0, 16'h0, 0, 0);
         chk("bp.vld", 80'(ifa.rob_c0_rdvalid), 80'(1));
         chk("bp.order", 80'(ifa.rob_c0_hdr.mdata), 80'(16'h0200 + 16'(k)));
      end
      step(0, 16'h0, 0, 0);
      chk("bp.drained", 80'(ifa.rob_c0_rdvalid), 80'(0));

      // FIFO almost-full and overflow
      assert_reset();
      release_reset();
      for (int k = 0; k < 9; k++) begin
         step(1, 16'h0300 + 16'(k), 1, 0);
         if (k == 2) chk("alm.after3", 80'(ifa.afu_c0_almfull), 80'(0));
         if (k == 3) chk("alm.after4", 80'(ifa.afu_c0_almfull), 80'(1));
         if (k == 7) chk("ovf.after8", 80'(ifa.overflow_err), 80'(0));
      end
      chk("ovf.after9", 80'(ifa.overflow_err), 80'(1));
      issued_b = 0;
      repeat (10) begin
         step(0, 16'h0, 0, 0);
         issued_b += int'(ifb.rob_c0_rdvalid);
      end
      chk("ovf.b_issued", 80'(issued_b), 80'(8));
      chk("ovf.b_last", 80'(ifb.rob_c0_hdr.mdata), 80'(16'h0307));
      chk("ovf.sticky", 80'(ifa.overflow_err), 80'(1));

      // simultaneous issue and response, then a spurious response
      assert_reset();
      release_reset();
      for (int k = 0; k < 4; k++) step(1, 16'h0400 + 16'(k), 0, 0);
      chk("sim.out_pre", 80'(ifa.outstanding), 80'(3));
      step(0, 16'h0, 0, 1);
      chk("sim.vld", 80'(ifa.rob_c0_rdvalid), 80'(1));
      chk("sim.out", 80'(ifa.outstanding), 80'(3));
      assert_reset();
      release_reset();
      step(0, 16'h0, 0, 1);
      chk("unf.out", 80'(ifa.outstanding), 80'(0));
      chk("unf.flag", 80'(ifa.underflow_err), 80'(1));
      step(0, 16'h0, 0, 0);
      chk("unf.sticky", 80'(ifa.underflow_err), 80'(1));

      // asynchronous reset mid-stream on the 8-credit instance
      assert_reset();
      release_reset();
      for (int k = 0; k < 5; k++) step(1, 16'h0500 + 16'(k), 0, 0);
      step(0, 16'h0, 0, 0);
      step(1, 16'h0505, 1, 0);
      step(1, 16'h0506, 1, 0);
      chk("mid.out_pre", 80'(ifb.outstanding), 80'(5));
      chk("mid.state_pre", 80'(ifb.gate_state), 80'(3));
      drv_vld = 0; drv_ralm = 0;
      #3;
      softreset = 1'b1;
      #1;
      model_reset();
      chk("mid.rst_out", 80'(ifb.outstanding), 80'(0));
      chk("mid.rst_alm", 80'(ifb.afu_c0_almfull), 80'(1));
      chk("mid.rst_state", 80'(ifb.gate_state), 80'(0));
      chk("mid.rst_vld", 80'(ifb.rob_c0_rdvalid), 80'(0));
      check_all();
      @(posedge clk);
      #1;
      release_reset();
      for (int k = 0; k < 3; k++) begin
         step(0, 16'h0, 0, 0);
         chk("mid.no_issue", 80'(ifb.rob_c0_rdvalid), 80'(0));
      end

      // randomized traffic against the model
      assert_reset();
      release_reset();
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom_range(0, 1)), 16'($urandom),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
